// File: rtl/dac_sched_pkg.sv
// Shared types and constants for the quad-DAC update scheduler.
// DAC_SCHED_LDAC_EN adds the LDAC latch state.
package dac_sched_pkg;

    localparam int          CH_W              = 3;
    localparam logic [15:0] MIDSCALE_DEF      = 16'h8000;
    localparam int          LDAC_PULSE_CYCLES = 4;

`ifdef DAC_SCHED_LDAC_EN
    typedef enum logic [1:0] {IDLE, GRANT, SEND, LDAC} sched_state_e;
`else
    typedef enum logic [1:0] {IDLE, GRANT, SEND} sched_state_e;
`endif

    // Next channel after ch, wrapping at n channels
    function automatic logic [CH_W-1:0] ch_next(input logic [CH_W-1:0] ch, input int n);
        return (int'(ch) + 1 >= n) ? '0 : ch + 1'b1;
    endfunction

endpackage

// File: rtl/dac_update_sched_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Unaffected by DAC_SCHED_LDAC_EN.
module rr_arbiter
    import dac_sched_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   gnt,
    output logic              gnt_vld
);

    int idx;

    // Scan from the far end toward ptr so the closest request is written last
    always_comb begin
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (req[idx]) begin
                gnt     = CH_W'(idx);
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_update_sched.sv
// Round-robin update scheduler for the shared quad serial DAC, with midscale
// substitution and background refresh. DAC_SCHED_LDAC_EN adds dac_ldac.
module dac_update_sched
    import dac_sched_pkg::*;
#(
    parameter int                NUM_CH      = 4,
    parameter int                DATA_W      = 16,
    parameter logic [15:0]       REFRESH_DIV = 16'd4096,
    parameter logic [DATA_W-1:0] MIDSCALE    = DATA_W'(MIDSCALE_DEF)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        cmd_wen,
    input  logic [NUM_CH*DATA_W-1:0] cmd_data,
    input  logic [NUM_CH-1:0]        amp_disable,
    output logic                     spi_req,
    output logic [CH_W-1:0]          spi_ch,
    output logic [DATA_W-1:0]        spi_data,
    input  logic                     spi_done,
    output logic [NUM_CH-1:0]        pending,
    output logic                     sched_busy,
    output logic [15:0]              upd_count
`ifdef DAC_SCHED_LDAC_EN
    ,
    output logic                     dac_ldac
`endif
);

    sched_state_e state, state_nxt;

    logic [NUM_CH-1:0][DATA_W-1:0] cmd_words;
    logic [CH_W-1:0]   rr_ptr, arb_ch, gnt_ch;
    logic              arb_vld;
    logic [15:0]       ref_cnt;
    logic              ref_tick;
    logic [DATA_W-1:0] sel_word;
    logic              sel_dis;
    logic [NUM_CH-1:0] grant_mask, pend_nxt;

    assign cmd_words  = cmd_data;
    assign sched_busy = (state != IDLE);

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req     (pending),
        .ptr     (rr_ptr),
        .gnt     (arb_ch),
        .gnt_vld (arb_vld)
    );

    // Refresh divider: REFRESH_DIV of zero pins the counter and never ticks
    assign ref_tick = (REFRESH_DIV != 16'd0) && (ref_cnt == REFRESH_DIV - 16'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                      ref_cnt <= '0;
        else if (REFRESH_DIV == 16'd0)   ref_cnt <= '0;
        else if (ref_tick)               ref_cnt <= '0;
        else                             ref_cnt <= ref_cnt + 16'd1;
    end

    always_comb begin
        sel_word   = '0;
        sel_dis    = 1'b0;
        grant_mask = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_ch == CH_W'(i)) begin
                sel_word      = cmd_words[i];
                sel_dis       = amp_disable[i];
                grant_mask[i] = 1'b1;
            end
        end
    end

    // A new write in the grant cycle re-arms the channel: set beats clear
    always_comb begin
        pend_nxt = pending;
        if (state == GRANT) pend_nxt = pend_nxt & ~grant_mask;
        pend_nxt = pend_nxt | cmd_wen | {NUM_CH{ref_tick}};
    end

`ifdef DAC_SCHED_LDAC_EN
    logic [2:0] ldac_cnt;

    assign dac_ldac = (state == LDAC);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)               ldac_cnt <= '0;
        else if (state == LDAC)   ldac_cnt <= ldac_cnt + 3'd1;
        else                      ldac_cnt <= '0;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (arb_vld) state_nxt = GRANT;
            GRANT: state_nxt = SEND;
            SEND: begin
                if (spi_done) begin
`ifdef DAC_SCHED_LDAC_EN
                    state_nxt = (pending == '0) ? LDAC : IDLE;
`else
                    state_nxt = IDLE;
`endif
                end
            end
`ifdef DAC_SCHED_LDAC_EN
            LDAC:  if (ldac_cnt == 3'(LDAC_PULSE_CYCLES - 1)) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending   <= '0;
            rr_ptr    <= '0;
            gnt_ch    <= '0;
            spi_req   <= 1'b0;
            spi_ch    <= '0;
            spi_data  <= MIDSCALE;
            upd_count <= '0;
        end else begin
            pending <= pend_nxt;
            if (state == IDLE && arb_vld) gnt_ch <= arb_ch;
            // Word is sampled here, so the newest command wins
            if (state == GRANT) begin
                spi_ch   <= gnt_ch;
                spi_data <= sel_dis ? MIDSCALE : sel_word;
                rr_ptr   <= ch_next(gnt_ch, NUM_CH);
                spi_req  <= 1'b1;
            end
            if (state == SEND && spi_done) begin
                spi_req   <= 1'b0;
                upd_count <= upd_count + 16'd1;
            end
        end
    end

endmodule
